// File: rtl/serial_out_if.sv
// Bundle of the serializer's control, RAM-read and serial-output signals.
// master: the serializer itself. slave: the surrounding system (RAM, requester, receiver).
interface serial_out_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned FEAT_W     = 4,
    parameter int unsigned CNT_W      = 12
);
    logic                  start;
    logic [CNT_W-1:0]      num_dp;
    logic [FEAT_W-1:0]     feat;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ser;
    logic                  ser_valid;
    logic                  sor;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, num_dp, feat, rd_data,
        output addr, rd_en, ser, ser_valid, sor, busy, done
    );

    modport slave (
        output start, num_dp, feat, rd_data,
        input  addr, rd_en, ser, ser_valid, sor, busy, done
    );
endinterface

// File: rtl/serial_out.sv
// Dataset serializer: reads records 0..num_dp from RAM and streams each record's
// bit window LO..HI (LSB first) one bit per clock, back-to-back with no idle bits.
// The next record is prefetched while the current one is still shifting.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit after every record.
module serial_out #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned MAX_FEATURES = 15,
    parameter int unsigned LENGTH       = 16,
    parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    serial_out_if.master bus
);

    localparam int unsigned FEAT_W = $clog2(MAX_FEATURES + 1);
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);

    // Window top bit and the prefetch point two bits before it.
    localparam logic [IDX_W-1:0] HI     = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] PF_IDX = IDX_W'(DATA_WIDTH - 3);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift,
        StParity,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      rec_cnt_q, rec_cnt_d;
    logic [CNT_W-1:0]      num_dp_q, num_dp_d;
    logic [FEAT_W-1:0]     feat_q, feat_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] next_buf_q, next_buf_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pf_pend_q, pf_pend_d;
`ifdef SER_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ser;
    logic                  ser_valid;
    logic                  sor;
    logic                  busy;
    logic                  done;

    logic [IDX_W-1:0]      lo;
    logic                  last_rec;
    int unsigned           rl_bits;

    // Lowest window bit for the latched feature count; the window always ends at HI.
    always_comb begin
        rl_bits  = LENGTH * (32'(feat_q) + 32'd1);
        lo       = IDX_W'(DATA_WIDTH - rl_bits);
        last_rec = (rec_cnt_q == num_dp_q);
    end

    // Next-state, datapath updates and all outputs.
    always_comb begin
        state_d    = state_q;
        rec_cnt_d  = rec_cnt_q;
        num_dp_d   = num_dp_q;
        feat_d     = feat_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pf_pend_d  = 1'b0;
        // Prefetched word arrives the cycle after its read strobe.
        next_buf_d = pf_pend_q ? bus.rd_data : next_buf_q;
`ifdef SER_PARITY_EN
        par_d      = par_q;
`endif
        rd_en      = 1'b0;
        addr       = addr_q;
        ser        = 1'b0;
        ser_valid  = 1'b0;
        sor        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StFetch;
                    rec_cnt_d = '0;
                    num_dp_d  = bus.num_dp;
                    feat_d    = bus.feat;
                end
            end

            StFetch: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                addr    = ADDR_WIDTH'(rec_cnt_q);
                state_d = StLoad;
            end

            StLoad: begin
                busy      = 1'b1;
                shift_d   = bus.rd_data;
                bit_idx_d = lo;
                state_d   = StShift;
            end

            StShift: begin
                busy      = 1'b1;
                ser       = shift_q[bit_idx_q];
                ser_valid = 1'b1;
                sor       = (bit_idx_q == lo);
`ifdef SER_PARITY_EN
                par_d     = sor ? ser : (par_q ^ ser);
`endif
                // Fetch the following record early so the boundary needs no gap cycle.
                if (bit_idx_q == PF_IDX && !last_rec) begin
                    rd_en     = 1'b1;
                    addr      = ADDR_WIDTH'(rec_cnt_q + CNT_W'(1));
                    pf_pend_d = 1'b1;
                end
                if (bit_idx_q == HI) begin
`ifdef SER_PARITY_EN
                    state_d = StParity;
`else
                    if (last_rec) begin
                        state_d = StDone;
                    end else begin
                        shift_d   = next_buf_q;
                        bit_idx_d = lo;
                        rec_cnt_d = rec_cnt_q + CNT_W'(1);
                    end
`endif
                end else begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end

            StParity: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
`ifdef SER_PARITY_EN
                ser       = par_q;
`endif
                if (last_rec) begin
                    state_d = StDone;
                end else begin
                    shift_d   = next_buf_q;
                    bit_idx_d = lo;
                    rec_cnt_d = rec_cnt_q + CNT_W'(1);
                    state_d   = StShift;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Address holds its last driven value between reads.
        addr_d = addr;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            rec_cnt_q  <= '0;
            num_dp_q   <= '0;
            feat_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            next_buf_q <= '0;
            addr_q     <= '0;
            pf_pend_q  <= 1'b0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rec_cnt_q  <= rec_cnt_d;
            num_dp_q   <= num_dp_d;
            feat_q     <= feat_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            next_buf_q <= next_buf_d;
            addr_q     <= addr_d;
            pf_pend_q  <= pf_pend_d;
`ifdef SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.rd_en     = rd_en;
        bus.addr      = addr;
        bus.ser       = ser;
        bus.ser_valid = ser_valid;
        bus.sor       = sor;
        bus.busy      = busy;
        bus.done      = done;
    end

endmodule

// File: tb/tb_serial_out.sv
// Scoreboard bench for serial_out: the driver pushes expected serial bits, read strobes
// and done pulses (with their cycle numbers) into queues; a monitor pops and compares.
module tb_serial_out;

    localparam int unsigned DW = 256;
`ifdef SER_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    typedef struct {
        logic        ser;
        logic        sor;
        int unsigned cyc;
    } bit_t;

    typedef struct {
        logic [11:0] addr;
        int unsigned cyc;
    } rd_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    bit_t        ser_q[$];
    rd_t         rd_q[$];
    int unsigned done_q[$];

    logic [DW-1:0] mem [0:15];

    serial_out_if bus ();

    serial_out dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // One-cycle-latency RAM model.
    always @(posedge CLK) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.addr[3:0]];
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every presented output event must match the head of its queue.
    always @(negedge CLK) begin
        bit_t        eb;
        rd_t         er;
        int unsigned ed;
        if (bus.ser_valid) begin
            if (ser_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ser_valid at cycle %0d got 1 want 0", cyc);
            end else begin
                eb = ser_q.pop_front();
                check("ser", bus.ser, eb.ser);
                check("sor", bus.sor, eb.sor);
                check("ser_cycle", cyc, eb.cyc);
            end
        end
        if (bus.rd_en) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rd_en at cycle %0d addr %0h got 1 want 0", cyc, bus.addr);
            end else begin
                er = rd_q.pop_front();
                check("rd_addr", bus.addr, er.addr);
                check("rd_cycle", cyc, er.cyc);
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done at cycle %0d got 1 want 0", cyc);
            end else begin
                ed = done_q.pop_front();
                check("done_cycle", cyc, ed);
            end
        end
    end

    // Expected events for a transfer accepted at the edge ending cycle t; events after cut dropped.
    task automatic push_exp(input int unsigned t, input int unsigned nd, input int unsigned ft,
                            input int unsigned cut);
        int unsigned rl;
        int unsigned lo;
        int unsigned base;
        logic        par;
        logic        b;
        bit_t        eb;
        rd_t         er;
        rl = 16 * (ft + 1);
        lo = DW - rl;
        if (t + 1 <= cut) begin
            er.addr = 12'd0;
            er.cyc  = t + 1;
            rd_q.push_back(er);
        end
        for (int unsigned r = 0; r <= nd; r++) begin
            base = t + 3 + r * (rl + PAR);
            par  = 1'b0;
            for (int unsigned k = 0; k < rl; k++) begin
                b   = mem[4'(r)][lo + k];
                par = par ^ b;
                if (base + k <= cut) begin
                    eb.ser = b;
                    eb.sor = (k == 0);
                    eb.cyc = base + k;
                    ser_q.push_back(eb);
                end
            end
`ifdef SER_PARITY_EN
            if (base + rl <= cut) begin
                eb.ser = par;
                eb.sor = 1'b0;
                eb.cyc = base + rl;
                ser_q.push_back(eb);
            end
`endif
            if (r < nd && base + rl - 3 <= cut) begin
                er.addr = 12'(r + 1);
                er.cyc  = base + rl - 3;
                rd_q.push_back(er);
            end
        end
        if (t + 3 + (nd + 1) * (rl + PAR) <= cut) done_q.push_back(t + 3 + (nd + 1) * (rl + PAR));
    endtask

    // Pulse start for one cycle, then scramble inputs to prove they were latched.
    task automatic start_xfer(input int unsigned nd, input int unsigned ft, input bit use_cut,
                              input int unsigned cut_off, output int unsigned t);
        @(negedge CLK);
        bus.num_dp = 12'(nd);
        bus.feat   = 4'(ft);
        bus.start  = 1'b1;
        t = cyc;
        push_exp(t, nd, ft, use_cut ? t + cut_off : 32'hFFFF_FFFF);
        @(negedge CLK);
        bus.start  = 1'b0;
        bus.num_dp = 12'hFFF;
        bus.feat   = 4'(ft) ^ 4'hF;
        check("busy_after_start", bus.busy, 1'b1);
    endtask

    task automatic wait_done(input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (!bus.done && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no done want done", name);
        end
        @(negedge CLK);
        @(negedge CLK);
        check({name, "_ser_left"}, ser_q.size(), 0);
        check({name, "_rd_left"}, rd_q.size(), 0);
        check({name, "_done_left"}, done_q.size(), 0);
        check({name, "_busy_idle"}, bus.busy, 1'b0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ser"}, bus.ser, 1'b0);
        check({name, "_ser_valid"}, bus.ser_valid, 1'b0);
        check({name, "_sor"}, bus.sor, 1'b0);
        check({name, "_busy"}, bus.busy, 1'b0);
        check({name, "_done"}, bus.done, 1'b0);
        check({name, "_rd_en"}, bus.rd_en, 1'b0);
        check({name, "_addr"}, bus.addr, 12'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        bus.start   = 1'b0;
        bus.num_dp  = '0;
        bus.feat    = '0;
        bus.rd_data = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 8; j++) mem[i][j*32 +: 32] = 32'h9E37_79B9 * 32'(i * 8 + j + 1);
        end

        // Reset state, with start held high to show reset wins.
        repeat (3) @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        check_quiet("reset");
        bus.start = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        check_quiet("idle");

        // Single minimum-length record: A5C3 -> 1100001110100101 on the line.
        mem[0] = '0;
        mem[0][255:240] = 16'hA5C3;
        start_xfer(0, 0, 1'b0, 0, t);
        wait_done(100, "single");

        // Three full records with stray start pulses mid-transfer.
        for (int j = 0; j < 8; j++) mem[0][j*32 +: 32] = 32'hC001_D00D + 32'(j * 17);
        start_xfer(2, 15, 1'b0, 0, t);
        while (cyc < t + 5) @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        while (cyc < t + 100) @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        wait_done(1000, "full3");

        // Reset during bit 40 of record 1, then a clean restart from address 0.
        start_xfer(2, 15, 1'b1, 3 + 256 + 40, t);
        while (cyc < t + 3 + 256 + 40) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_quiet("abort");
        check("abort_ser_left", ser_q.size(), 0);
        check("abort_rd_left", rd_q.size(), 0);
        RST = 1'b0;
        start_xfer(1, 1, 1'b0, 0, t);
        wait_done(200, "restart");

        // Six medium records (feat=3).
        start_xfer(5, 3, 1'b0, 0, t);
        wait_done(600, "feat3");

        // Parity vectors: 0001 has odd weight, 0003 even.
        mem[0] = '0;
        mem[0][255:240] = 16'h0001;
        mem[1] = '0;
        mem[1][255:240] = 16'h0003;
        start_xfer(1, 0, 1'b0, 0, t);
        wait_done(100, "parity");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
